fft_frame_serializer: RTL and testbench

FFT_FRAME_SERIALIZER -- requirements
Module: fft_frame_serializer

---
 rtl/fft_frame_serializer.sv | 173 +++++++++++++++++
 tb/tb_fft_frame_serializer.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_serializer
//  Description : Captures a 16-point complex frame in parallel and streams it
//                out one sample per accepted beat with valid/ready flow
//                control. The emission order is natural, or bit-reversed when
//                BITREV=1.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    i_clk              system clock, rising edge
//    i_rst              asynchronous active-high reset
//    i_load             frame-capture request
//    in<k>_re/in<k>_im  parallel frame, point k = 0..15, N-bit two's complement
//    i_ready            downstream can accept a sample this cycle
//    o_valid            o_re/o_im/o_idx/o_last hold a valid sample
//    o_re/o_im          current sample
//    o_idx              frame index of the current sample
//    o_last             final (16th) sample of the frame
//    o_busy             a frame is held and not yet fully sent
//    o_done             one-cycle pulse after the final sample is accepted
// ============================================================================
module fft_frame_serializer #(
   parameter int N      = 16,
   parameter int BITREV = 0
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [N-1:0] in0_re,  in0_im,
   input  logic [N-1:0] in1_re,  in1_im,
   input  logic [N-1:0] in2_re,  in2_im,
   input  logic [N-1:0] in3_re,  in3_im,
   input  logic [N-1:0] in4_re,  in4_im,
   input  logic [N-1:0] in5_re,  in5_im,
   input  logic [N-1:0] in6_re,  in6_im,
   input  logic [N-1:0] in7_re,  in7_im,
   input  logic [N-1:0] in8_re,  in8_im,
   input  logic [N-1:0] in9_re,  in9_im,
   input  logic [N-1:0] in10_re, in10_im,
   input  logic [N-1:0] in11_re, in11_im,
   input  logic [N-1:0] in12_re, in12_im,
   input  logic [N-1:0] in13_re, in13_im,
   input  logic [N-1:0] in14_re, in14_im,
   input  logic [N-1:0] in15_re, in15_im,
   input  logic         i_ready,
   output logic         o_valid,
   output logic [N-1:0] o_re,
   output logic [N-1:0] o_im,
   output logic [3:0]   o_idx,
   output logic         o_last,
   output logic         o_busy,
   output logic         o_done
);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t       state, state_nxt;
   logic [3:0]   beat, beat_nxt;
   logic [3:0]   idx;
   logic         capture;
   logic         final_xfer;
   logic         done_q;
   logic         sending;
   logic [N-1:0] in_re   [16];
   logic [N-1:0] in_im   [16];
   logic [N-1:0] bank_re [16];
   logic [N-1:0] bank_im [16];

   // Gather the flat port list into arrays so the bank can be loaded by loop.
   assign in_re[0]  = in0_re;   assign in_im[0]  = in0_im;
   assign in_re[1]  = in1_re;   assign in_im[1]  = in1_im;
   assign in_re[2]  = in2_re;   assign in_im[2]  = in2_im;
   assign in_re[3]  = in3_re;   assign in_im[3]  = in3_im;
   assign in_re[4]  = in4_re;   assign in_im[4]  = in4_im;
   assign in_re[5]  = in5_re;   assign in_im[5]  = in5_im;
   assign in_re[6]  = in6_re;   assign in_im[6]  = in6_im;
   assign in_re[7]  = in7_re;   assign in_im[7]  = in7_im;
   assign in_re[8]  = in8_re;   assign in_im[8]  = in8_im;
   assign in_re[9]  = in9_re;   assign in_im[9]  = in9_im;
   assign in_re[10] = in10_re;  assign in_im[10] = in10_im;
   assign in_re[11] = in11_re;  assign in_im[11] = in11_im;
   assign in_re[12] = in12_re;  assign in_im[12] = in12_im;
   assign in_re[13] = in13_re;  assign in_im[13] = in13_im;
   assign in_re[14] = in14_re;  assign in_im[14] = in14_im;
   assign in_re[15] = in15_re;  assign in_im[15] = in15_im;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // A load is honoured in IDLE, or on the edge that retires beat 15 so that
   // frames can follow each other without an idle cycle.
   always_comb begin
      state_nxt  = state;
      beat_nxt   = beat;
      capture    = 1'b0;
      final_xfer = 1'b0;
      case (state)
         IDLE: begin
            if (i_load) begin
               capture   = 1'b1;
               beat_nxt  = 4'd0;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (i_ready) begin
               final_xfer = (beat == 4'd15);
               beat_nxt   = beat + 4'd1;
               if (beat == 4'd15) begin
                  if (i_load) begin
                     capture  = 1'b1;
                     beat_nxt = 4'd0;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         beat   <= 4'd0;
         done_q <= 1'b0;
      end else begin
         beat   <= beat_nxt;
         done_q <= final_xfer;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         for (int k = 0; k < 16; k++) begin
            bank_re[k] <= '0;
            bank_im[k] <= '0;
         end
      end else if (capture) begin
         for (int k = 0; k < 16; k++) begin
            bank_re[k] <= in_re[k];
            bank_im[k] <= in_im[k];
         end
      end
   end

   generate
      if (BITREV != 0) begin : g_bitrev
         assign idx = {beat[0], beat[1], beat[2], beat[3]};
      end else begin : g_linear
         assign idx = beat;
      end
   endgenerate

   // Outputs decode registered state only; nothing from i_ready, i_load or
   // the frame inputs reaches them combinationally.
   assign sending = (state == SEND);
   assign o_valid = sending;
   assign o_busy  = sending;
   assign o_last  = sending && (beat == 4'd15);
   assign o_idx   = sending ? idx : 4'd0;
   assign o_re    = sending ? bank_re[idx] : '0;
   assign o_im    = sending ? bank_im[idx] : '0;
   assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_serializer
//  Description : Self-checking bench for fft_frame_serializer. Two instances
//                (natural and bit-reversed order) share stimulus; expected
//                beats are queued at load time and compared as they stream.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fft_frame_serializer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, load, ready;
   logic [15:0] in_re [16];
   logic [15:0] in_im [16];

   logic        v0, last0, busy0, done0;
   logic [15:0] re0, im0;
   logic [3:0]  idx0;
   logic        v1, last1, busy1, done1;
   logic [15:0] re1, im1;
   logic [3:0]  idx1;

   typedef struct packed {
      logic [15:0] re;
      logic [15:0] im;
      logic [3:0]  idx;
      logic        last;
   } beat_t;

   beat_t q0[$];
   beat_t q1[$];
   int checks = 0;
   int passed = 0;
   int rev_seq [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

   fft_frame_serializer #(.N(16), .BITREV(0)) dut0 (
      .i_clk(clk), .i_rst(rst), .i_load(load),
      .in0_re(in_re[0]),   .in0_im(in_im[0]),   .in1_re(in_re[1]),   .in1_im(in_im[1]),
      .in2_re(in_re[2]),   .in2_im(in_im[2]),   .in3_re(in_re[3]),   .in3_im(in_im[3]),
      .in4_re(in_re[4]),   .in4_im(in_im[4]),   .in5_re(in_re[5]),   .in5_im(in_im[5]),
      .in6_re(in_re[6]),   .in6_im(in_im[6]),   .in7_re(in_re[7]),   .in7_im(in_im[7]),
      .in8_re(in_re[8]),   .in8_im(in_im[8]),   .in9_re(in_re[9]),   .in9_im(in_im[9]),
      .in10_re(in_re[10]), .in10_im(in_im[10]), .in11_re(in_re[11]), .in11_im(in_im[11]),
      .in12_re(in_re[12]), .in12_im(in_im[12]), .in13_re(in_re[13]), .in13_im(in_im[13]),
      .in14_re(in_re[14]), .in14_im(in_im[14]), .in15_re(in_re[15]), .in15_im(in_im[15]),
      .i_ready(ready), .o_valid(v0), .o_re(re0), .o_im(im0), .o_idx(idx0),
      .o_last(last0), .o_busy(busy0), .o_done(done0)
   );

   fft_frame_serializer #(.N(16), .BITREV(1)) dut1 (
      .i_clk(clk), .i_rst(rst), .i_load(load),
      .in0_re(in_re[0]),   .in0_im(in_im[0]),   .in1_re(in_re[1]),   .in1_im(in_im[1]),
      .in2_re(in_re[2]),   .in2_im(in_im[2]),   .in3_re(in_re[3]),   .in3_im(in_im[3]),
      .in4_re(in_re[4]),   .in4_im(in_im[4]),   .in5_re(in_re[5]),   .in5_im(in_im[5]),
      .in6_re(in_re[6]),   .in6_im(in_im[6]),   .in7_re(in_re[7]),   .in7_im(in_im[7]),
      .in8_re(in_re[8]),   .in8_im(in_im[8]),   .in9_re(in_re[9]),   .in9_im(in_im[9]),
      .in10_re(in_re[10]), .in10_im(in_im[10]), .in11_re(in_re[11]), .in11_im(in_im[11]),
      .in12_re(in_re[12]), .in12_im(in_im[12]), .in13_re(in_re[13]), .in13_im(in_im[13]),
      .in14_re(in_re[14]), .in14_im(in_im[14]), .in15_re(in_re[15]), .in15_im(in_im[15]),
      .i_ready(ready), .o_valid(v1), .o_re(re1), .o_im(im1), .o_idx(idx1),
      .o_last(last1), .o_busy(busy1), .o_done(done1)
   );

   // Frame k: re = base+k, im = -(base+k)
   task automatic set_frame(input int base);
      for (int k = 0; k < 16; k++) begin
         in_re[k] = 16'(base + k);
         in_im[k] = 16'(-(base + k));
      end
   endtask

   // Queue the expected emission of the frame currently on the inputs.
   task automatic push_frame(input bit rev);
      beat_t e;
      int    k;
      for (int b = 0; b < 16; b++) begin
         k      = rev ? rev_seq[b] : b;
         e.re   = in_re[k];
         e.im   = in_im[k];
         e.idx  = 4'(k);
         e.last = (b == 15);
         if (rev) q1.push_back(e);
         else     q0.push_back(e);
      end
   endtask

   task automatic test_reset;
      rst   = 1'b1;
      load  = 1'b1;
      ready = 1'b1;
      set_frame(77);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({v0, busy0, last0, done0} !== 4'b0000) $display("FAIL reset_flags0: got %b want 0000", {v0, busy0, last0, done0});
      else passed++;
      checks++;
      if ({idx0, re0, im0} !== 36'd0) $display("FAIL reset_data0: got idx=%0d re=%h im=%h want 0", idx0, re0, im0);
      else passed++;
      checks++;
      if ({v1, busy1, last1, done1, idx1, re1, im1} !== 40'd0) $display("FAIL reset_dut1: got v=%b idx=%0d re=%h want all 0", v1, idx1, re1);
      else passed++;
      load = 1'b0;
      rst  = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({v0, busy0, done0} !== 3'b000) $display("FAIL idle_after_reset: got %b want 000", {v0, busy0, done0});
      else passed++;
   endtask

   task automatic test_basic;
      beat_t e;
      int    n = 0;
      set_frame(0);
      push_frame(1'b0);
      load  = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      checks++;
      if ({v0, busy0, idx0, re0} !== {2'b11, 4'd0, 16'd0}) $display("FAIL load_latency: got v=%b busy=%b idx=%0d re=%h want v=1 busy=1 idx=0 re=0", v0, busy0, idx0, re0);
      else passed++;
      for (int c = 0; c < 40 && n < 16; c++) begin
         @(negedge clk);
         checks++;
         if (!v0 || q0.size() == 0) $display("FAIL basic_valid beat %0d: got valid=%b qsize=%0d want valid=1", n, v0, q0.size());
         else begin
            e = q0.pop_front();
            n++;
            if ({re0, im0, idx0, last0, busy0, done0} !== {e.re, e.im, e.idx, e.last, 1'b1, 1'b0})
               $display("FAIL basic_beat %0d: got re=%h im=%h idx=%0d last=%b busy=%b done=%b want re=%h im=%h idx=%0d last=%b busy=1 done=0",
                        n-1, re0, im0, idx0, last0, busy0, done0, e.re, e.im, e.idx, e.last);
            else passed++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({v0, busy0, done0} !== 3'b001) $display("FAIL basic_done: got valid/busy/done=%b want 001 (beats=%0d)", {v0, busy0, done0}, n);
      else passed++;
      @(posedge clk); #1;
      checks++;
      if (done0 !== 1'b0) $display("FAIL basic_done_width: got done=%b want 0", done0);
      else passed++;
   endtask

   task automatic test_stall;
      int n = 0;
      set_frame(100);
      push_frame(1'b0);
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      for (int c = 0; c < 80 && n < 16; c++) begin
         ready = (c % 3 == 0);
         @(negedge clk);
         checks++;
         if (!v0 || q0.size() == 0) $display("FAIL stall_valid cycle %0d: got valid=%b want 1", c, v0);
         else if ({re0, im0, idx0, last0, done0} !== {q0[0].re, q0[0].im, q0[0].idx, q0[0].last, 1'b0})
            $display("FAIL stall_beat %0d ready=%b: got re=%h idx=%0d last=%b done=%b want re=%h idx=%0d last=%b done=0",
                     n, ready, re0, idx0, last0, done0, q0[0].re, q0[0].idx, q0[0].last);
         else passed++;
         if (v0 && ready && q0.size() != 0) begin
            void'(q0.pop_front());
            n++;
         end
         @(posedge clk); #1;
      end
      ready = 1'b1;
      checks++;
      if ({n[4:0], v0, done0} !== {5'd16, 1'b0, 1'b1}) $display("FAIL stall_end: got beats=%0d valid=%b done=%b want 16/0/1", n, v0, done0);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_bitrev;
      beat_t e;
      int    n = 0;
      set_frame(0);
      push_frame(1'b1);
      load  = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      for (int c = 0; c < 40 && n < 16; c++) begin
         @(negedge clk);
         checks++;
         if (!v1 || q1.size() == 0) $display("FAIL bitrev_valid beat %0d: got valid=%b want 1", n, v1);
         else begin
            e = q1.pop_front();
            n++;
            if ({re1, im1, idx1, last1} !== {e.re, e.im, e.idx, e.last})
               $display("FAIL bitrev_beat %0d: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                        n-1, re1, im1, idx1, last1, e.re, e.im, e.idx, e.last);
            else passed++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({v1, busy1, done1} !== 3'b001) $display("FAIL bitrev_done: got valid/busy/done=%b want 001", {v1, busy1, done1});
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_load_ignored;
      beat_t e;
      int    n = 0;
      set_frame(200);
      push_frame(1'b0);
      load  = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 40 && n < 16; c++) begin
         load = 1'b0;
         @(negedge clk);
         checks++;
         if (!v0 || q0.size() == 0) $display("FAIL ignore_valid beat %0d: got valid=%b want 1", n, v0);
         else begin
            e = q0.pop_front();
            n++;
            if ({re0, im0, idx0, last0, done0} !== {e.re, e.im, e.idx, e.last, 1'b0})
               $display("FAIL ignore_beat %0d: got re=%h im=%h idx=%0d done=%b want re=%h im=%h idx=%0d done=0",
                        n-1, re0, im0, idx0, done0, e.re, e.im, e.idx);
            else passed++;
            if (n == 5) begin
               set_frame(900);
               load = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      load = 1'b0;
      checks++;
      if ({v0, done0} !== 2'b01) $display("FAIL ignore_done: got valid/done=%b want 01", {v0, done0});
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back;
      beat_t e;
      int    n = 0;
      set_frame(300);
      push_frame(1'b0);
      load  = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      for (int c = 0; c < 80 && n < 32; c++) begin
         load = 1'b0;
         @(negedge clk);
         checks++;
         if (!v0 || q0.size() == 0) $display("FAIL b2b_valid beat %0d: got valid=%b want 1", n, v0);
         else begin
            e = q0.pop_front();
            if ({re0, im0, idx0, last0, busy0, done0} !== {e.re, e.im, e.idx, e.last, 1'b1, (n == 16)})
               $display("FAIL b2b_beat %0d: got re=%h im=%h idx=%0d last=%b busy=%b done=%b want re=%h im=%h idx=%0d last=%b busy=1 done=%b",
                        n, re0, im0, idx0, last0, busy0, done0, e.re, e.im, e.idx, e.last, (n == 16));
            else passed++;
            n++;
            if (n == 16) begin
               set_frame(500);
               push_frame(1'b0);
               load = 1'b1;
            end
         end
         @(posedge clk); #1;
      end
      load = 1'b0;
      checks++;
      if ({v0, done0} !== 2'b01) $display("FAIL b2b_done: got valid/done=%b want 01 (beats=%0d)", {v0, done0}, n);
      else passed++;
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid;
      beat_t e;
      int    n = 0;
      set_frame(600);
      push_frame(1'b0);
      load  = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
      for (int c = 0; c < 40 && n < 7; c++) begin
         @(negedge clk);
         if (v0 && q0.size() != 0) begin
            void'(q0.pop_front());
            n++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({v0, idx0} !== {1'b1, 4'd7}) $display("FAIL rstmid_pre: got valid=%b idx=%0d want 1/7", v0, idx0);
      else passed++;
      rst = 1'b1;
      #1;
      checks++;
      if ({v0, busy0, last0, done0, idx0, re0, im0} !== 40'd0)
         $display("FAIL rstmid_async: got v=%b busy=%b idx=%0d re=%h im=%h want all 0", v0, busy0, idx0, re0, im0);
      else passed++;
      q0.delete();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({v0, done0} !== 2'b00) $display("FAIL rstmid_nodone cycle %0d: got valid/done=%b want 00", c, {v0, done0});
         else passed++;
      end
      @(negedge clk);
      rst = 1'b0;
      set_frame(700);
      push_frame(1'b0);
      load = 1'b1;
      n    = 0;
      @(posedge clk); #1;
      load = 1'b0;
      for (int c = 0; c < 40 && n < 16; c++) begin
         @(negedge clk);
         checks++;
         if (!v0 || q0.size() == 0) $display("FAIL rstmid_valid beat %0d: got valid=%b want 1", n, v0);
         else begin
            e = q0.pop_front();
            n++;
            if ({re0, im0, idx0, last0, done0} !== {e.re, e.im, e.idx, e.last, 1'b0})
               $display("FAIL rstmid_beat %0d: got re=%h im=%h idx=%0d last=%b want re=%h im=%h idx=%0d last=%b",
                        n-1, re0, im0, idx0, last0, e.re, e.im, e.idx, e.last);
            else passed++;
         end
         @(posedge clk); #1;
      end
      checks++;
      if ({v0, done0} !== 2'b01) $display("FAIL rstmid_done: got valid/done=%b want 01", {v0, done0});
      else passed++;
      @(posedge clk); #1;
   endtask

   initial begin
      rst   = 1'b1;
      load  = 1'b0;
      ready = 1'b0;
      set_frame(0);
      test_reset();
      test_basic();
      test_stall();
      test_bitrev();
      test_load_ignored();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
`default_nettype wire
